// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed scanner for a common-anode multi-digit hex display.
// It sits in front of a registered seven-segment decoder. It steps through
// the digits one slot at a time and presents each digit's nibble on
// NUMBER_OUT. The matching active-low enable is delayed by one cycle, so
// the enable and the decoder's registered segments change together.
// New values are staged in a shadow register and only reach the display at
// a frame boundary, so a frame never mixes two values.
//
// Ports:
//   CLK_IN        - single clock, rising edge
//   RST_IN        - synchronous active-high reset
//   VALUE_IN      - 4*DIGITS-bit value; nibble 0 is the rightmost digit
//   LOAD_IN       - one-cycle strobe that captures VALUE_IN
//   BLANK_LZ_IN   - 1 blanks leading zero digits (digit 0 is always shown)
//   NUMBER_OUT    - nibble for the current digit, feeds decoder NUMBER_IN
//   DIGIT_EN_OUT  - active-low one-hot digit enables, all 1s = all off
//   FRAME_OUT     - one-cycle pulse on the cycle the scan wraps to digit 0
module seven_segment_scanner #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  CLK_IN,
   input  logic                  RST_IN,
   input  logic [4*DIGITS-1:0]   VALUE_IN,
   input  logic                  LOAD_IN,
   input  logic                  BLANK_LZ_IN,
   output logic [3:0]            NUMBER_OUT,
   output logic [DIGITS-1:0]     DIGIT_EN_OUT,
   output logic                  FRAME_OUT
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [4*DIGITS-1:0] shadow;
   logic [4*DIGITS-1:0] active;
   logic                pending;
   logic [PW-1:0]       prescaler;
   logic [IW-1:0]       index;

   logic                slot_end;
   logic                frame_wrap;
   logic [IW-1:0]       index_next;
   logic [4*DIGITS-1:0] active_next;
   logic [DIGITS-1:0]   blank_mask;

   // Slot and frame timing, plus the value the display will hold after this
   // edge. A load that lands exactly on the frame wrap bypasses the shadow
   // so it is shown in the frame that starts at this edge.
   // A digit is blanked when blanking is on and it and every digit to its
   // left are zero; digit 0 is exempt so an all-zero value still shows "0".
   always_comb begin
      slot_end    = (prescaler == PRE_LAST);
      frame_wrap  = slot_end && (index == IDX_LAST);
      index_next  = index;
      active_next = active;
      blank_mask  = '0;
      FRAME_OUT   = frame_wrap && !RST_IN;

      if (slot_end) begin
         index_next = (index == IDX_LAST) ? '0 : index + 1'b1;
      end

      if (frame_wrap) begin
         if (LOAD_IN) begin
            active_next = VALUE_IN;
         end else if (pending) begin
            active_next = shadow;
         end
      end

      for (int i = 1; i < DIGITS; i++) begin
         blank_mask[i] = BLANK_LZ_IN && ((active >> (4 * i)) == '0);
      end
   end

   // All state. NUMBER_OUT moves to the new digit on the slot edge, while
   // the enables go dark on that edge and light one cycle later (on the
   // first cycle of the slot). That one-cycle gap lines up with the
   // decoder's register stage and gives dead time against ghosting.
   // The blank decision is taken at that same point and held for the slot.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         shadow       <= '0;
         active       <= '0;
         pending      <= 1'b0;
         prescaler    <= '0;
         index        <= '0;
         NUMBER_OUT   <= 4'h0;
         DIGIT_EN_OUT <= '1;
      end else begin
         prescaler <= slot_end ? '0 : prescaler + 1'b1;
         index     <= index_next;
         active    <= active_next;

         if (LOAD_IN) begin
            shadow <= VALUE_IN;
         end

         if (frame_wrap) begin
            pending <= 1'b0;
         end else if (LOAD_IN) begin
            pending <= 1'b1;
         end

         if (slot_end) begin
            NUMBER_OUT <= active_next[4*index_next +: 4];
         end

         if (slot_end) begin
            DIGIT_EN_OUT <= '1;
         end else if (prescaler == '0) begin
            DIGIT_EN_OUT <= blank_mask[index] ? '1 : ~(DIGITS'(1) << index);
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
// Directed bench for seven_segment_scanner with DIGITS=4, REFRESH_DIV=4.
// Time is tracked as n = number of rising edges since the last reset edge.
// With these parameters the scanner is on digit (n/4)%4, the first cycle of
// each slot (n%4==0) is dark, a frame is 16 cycles, FRAME_OUT is high when
// n%16==15 and new values appear at n%16==0.
module tb_seven_segment_scanner;

   logic        CLK_IN;
   logic        RST_IN;
   logic [15:0] VALUE_IN;
   logic        LOAD_IN;
   logic        BLANK_LZ_IN;
   logic [3:0]  NUMBER_OUT;
   logic [3:0]  DIGIT_EN_OUT;
   logic        FRAME_OUT;

   int n;
   int total;
   int bad;

   seven_segment_scanner #(.DIGITS(4), .REFRESH_DIV(4)) dut (
      .CLK_IN      (CLK_IN),
      .RST_IN      (RST_IN),
      .VALUE_IN    (VALUE_IN),
      .LOAD_IN     (LOAD_IN),
      .BLANK_LZ_IN (BLANK_LZ_IN),
      .NUMBER_OUT  (NUMBER_OUT),
      .DIGIT_EN_OUT(DIGIT_EN_OUT),
      .FRAME_OUT   (FRAME_OUT)
   );

   // Free-running 10-unit clock.
   initial begin
      CLK_IN = 1'b0;
      forever #5 CLK_IN = ~CLK_IN;
   end

   // Safety net in case something stalls the stimulus.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at n=%0d", n);
      $fatal(1, "[TB] watchdog");
   end

   // Expected enables at time n; lit[d]=0 means digit d should be blanked.
   function automatic logic [3:0] exp_en(input int t, input logic [3:0] lit);
      int d;
      d = (t / 4) % 4;
      if ((t % 4) == 0 || !lit[d]) return 4'hF;
      return ~(4'b0001 << d);
   endfunction

   // Expected nibble at time n for a displayed value v.
   function automatic logic [3:0] exp_num(input int t, input logic [15:0] v);
      int d;
      d = (t / 4) % 4;
      return v[d*4 +: 4];
   endfunction

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge CLK_IN);
      #1;
      n = n + 1;
   endtask

   // Advance until the display has just taken a new frame (n%16==0).
   task automatic to_frame_start();
      tick();
      while ((n % 16) != 0) tick();
   endtask

   // Reset held 3 cycles with a load attempted throughout; everything dark
   // and zero during reset, the cycle after, and the first frame after it.
   task automatic test_reset();
      RST_IN = 1'b1;
      VALUE_IN = 16'hFFFF;
      LOAD_IN = 1'b1;
      BLANK_LZ_IN = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n = 0;
         total++;
         if (DIGIT_EN_OUT !== 4'hF || NUMBER_OUT !== 4'h0 || FRAME_OUT !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hold c=%0d got en=%b num=%h frame=%b want en=1111 num=0 frame=0",
                     c, DIGIT_EN_OUT, NUMBER_OUT, FRAME_OUT);
         end
      end
      RST_IN = 1'b0;
      LOAD_IN = 1'b0;
      #1;
      total++;
      if (DIGIT_EN_OUT !== 4'hF || NUMBER_OUT !== 4'h0 || FRAME_OUT !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_after got en=%b num=%h frame=%b want en=1111 num=0 frame=0",
                  DIGIT_EN_OUT, NUMBER_OUT, FRAME_OUT);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         total++;
         if (NUMBER_OUT !== 4'h0 || DIGIT_EN_OUT !== exp_en(n, 4'hF) || FRAME_OUT !== ((n % 16) == 15)) begin
            bad++;
            $display("[TB] FAIL reset_zero n=%0d got num=%h en=%b frame=%b want num=0 en=%b frame=%b",
                     n, NUMBER_OUT, DIGIT_EN_OUT, FRAME_OUT, exp_en(n, 4'hF), (n % 16) == 15);
         end
      end
   endtask

   // Load 0x1234 and watch two full frames of scanning.
   task automatic test_scan_order();
      to_frame_start();
      VALUE_IN = 16'h1234;
      LOAD_IN = 1'b1;
      tick();
      LOAD_IN = 1'b0;
      to_frame_start();
      for (int c = 0; c < 32; c++) begin
         total++;
         if (NUMBER_OUT !== exp_num(n, 16'h1234) || DIGIT_EN_OUT !== exp_en(n, 4'hF) || FRAME_OUT !== ((n % 16) == 15)) begin
            bad++;
            $display("[TB] FAIL scan n=%0d got num=%h en=%b frame=%b want num=%h en=%b frame=%b",
                     n, NUMBER_OUT, DIGIT_EN_OUT, FRAME_OUT, exp_num(n, 16'h1234), exp_en(n, 4'hF), (n % 16) == 15);
         end
         tick();
      end
   endtask

   // 0x0050 with blanking lights digits 0,1; 0x0000 lights only digit 0;
   // with blanking off all four light again.
   task automatic test_blanking();
      logic [15:0] vals [3];
      logic [3:0]  lits [3];
      logic        blk  [3];
      vals[0] = 16'h0050; lits[0] = 4'b0011; blk[0] = 1'b1;
      vals[1] = 16'h0000; lits[1] = 4'b0001; blk[1] = 1'b1;
      vals[2] = 16'h0000; lits[2] = 4'b1111; blk[2] = 1'b0;
      for (int s = 0; s < 3; s++) begin
         BLANK_LZ_IN = blk[s];
         VALUE_IN = vals[s];
         LOAD_IN = 1'b1;
         tick();
         LOAD_IN = 1'b0;
         to_frame_start();
         for (int c = 0; c < 16; c++) begin
            total++;
            if (NUMBER_OUT !== exp_num(n, vals[s]) || DIGIT_EN_OUT !== exp_en(n, lits[s])) begin
               bad++;
               $display("[TB] FAIL blank s=%0d n=%0d got num=%h en=%b want num=%h en=%b",
                        s, n, NUMBER_OUT, DIGIT_EN_OUT, exp_num(n, vals[s]), exp_en(n, lits[s]));
            end
            tick();
         end
      end
   endtask

   // Loads arriving mid-frame must wait for the next frame; the last of
   // several loads in one frame is the one shown.
   task automatic test_tear_free();
      VALUE_IN = 16'h1234;
      LOAD_IN = 1'b1;
      tick();
      LOAD_IN = 1'b0;
      to_frame_start();
      for (int c = 0; c < 16; c++) begin
         total++;
         if (NUMBER_OUT !== exp_num(n, 16'h1234) || DIGIT_EN_OUT !== exp_en(n, 4'hF)) begin
            bad++;
            $display("[TB] FAIL tear_old n=%0d got num=%h en=%b want num=%h en=%b",
                     n, NUMBER_OUT, DIGIT_EN_OUT, exp_num(n, 16'h1234), exp_en(n, 4'hF));
         end
         LOAD_IN = ((n % 16) == 5);
         VALUE_IN = 16'hAAAA;
         tick();
      end
      LOAD_IN = 1'b0;
      for (int c = 0; c < 16; c++) begin
         total++;
         if (NUMBER_OUT !== 4'hA || DIGIT_EN_OUT !== exp_en(n, 4'hF)) begin
            bad++;
            $display("[TB] FAIL tear_new n=%0d got num=%h en=%b want num=a en=%b",
                     n, NUMBER_OUT, DIGIT_EN_OUT, exp_en(n, 4'hF));
         end
         LOAD_IN = ((n % 16) == 1) || ((n % 16) == 5);
         VALUE_IN = ((n % 16) == 1) ? 16'h1111 : 16'h2222;
         tick();
      end
      LOAD_IN = 1'b0;
      for (int c = 0; c < 16; c++) begin
         total++;
         if (NUMBER_OUT !== 4'h2 || DIGIT_EN_OUT !== exp_en(n, 4'hF)) begin
            bad++;
            $display("[TB] FAIL tear_last n=%0d got num=%h en=%b want num=2 en=%b",
                     n, NUMBER_OUT, DIGIT_EN_OUT, exp_en(n, 4'hF));
         end
         tick();
      end
   endtask

   // A load on the FRAME_OUT cycle goes straight into the new frame.
   task automatic test_load_on_boundary();
      while ((n % 16) != 15) tick();
      total++;
      if (FRAME_OUT !== 1'b1) begin
         bad++;
         $display("[TB] FAIL boundary_frame n=%0d got frame=%b want 1", n, FRAME_OUT);
      end
      VALUE_IN = 16'hBEEF;
      LOAD_IN = 1'b1;
      tick();
      LOAD_IN = 1'b0;
      VALUE_IN = 16'h0000;
      for (int c = 0; c < 32; c++) begin
         total++;
         if (NUMBER_OUT !== exp_num(n, 16'hBEEF) || DIGIT_EN_OUT !== exp_en(n, 4'hF)) begin
            bad++;
            $display("[TB] FAIL boundary n=%0d got num=%h en=%b want num=%h en=%b",
                     n, NUMBER_OUT, DIGIT_EN_OUT, exp_num(n, 16'hBEEF), exp_en(n, 4'hF));
         end
         tick();
      end
   endtask

   // One-cycle reset during digit 2 restarts the scan from a clean state.
   task automatic test_mid_reset();
      while ((n % 16) != 9) tick();
      RST_IN = 1'b1;
      tick();
      n = 0;
      RST_IN = 1'b0;
      total++;
      if (DIGIT_EN_OUT !== 4'hF || NUMBER_OUT !== 4'h0 || FRAME_OUT !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_now got en=%b num=%h frame=%b want en=1111 num=0 frame=0",
                  DIGIT_EN_OUT, NUMBER_OUT, FRAME_OUT);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         total++;
         if (NUMBER_OUT !== 4'h0 || DIGIT_EN_OUT !== exp_en(n, 4'hF) || FRAME_OUT !== ((n % 16) == 15)) begin
            bad++;
            $display("[TB] FAIL midreset n=%0d got num=%h en=%b frame=%b want num=0 en=%b frame=%b",
                     n, NUMBER_OUT, DIGIT_EN_OUT, FRAME_OUT, exp_en(n, 4'hF), (n % 16) == 15);
         end
      end
   endtask

   initial begin
      n = 0;
      total = 0;
      bad = 0;
      RST_IN = 1'b1;
      VALUE_IN = 16'hFFFF;
      LOAD_IN = 1'b1;
      BLANK_LZ_IN = 1'b0;
      test_reset();
      test_scan_order();
      test_blanking();
      test_tear_free();
      test_load_on_boundary();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
